// File: rtl/tratador_botoes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tratador_botoes: sync, debounce and single/chord classification    |
// | of the two push-buttons.  Revision: 1.0                            |
// +--------------------------------------------------------------------+
module tratador_botoes #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CHORD_CYCLES    = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] KEY,
  output logic       pulso_key0,
  output logic       pulso_key1,
  output logic       pedido_reset,
  output logic       key0_estavel,
  output logic       key1_estavel,
  output logic       ocupado
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW = (CHORD_CYCLES > 1) ? $clog2(CHORD_CYCLES) : 1;
  localparam logic [DW-1:0] C_DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_CH_LAST = CW'(CHORD_CYCLES - 1);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_ESPERA = 2'd1;
  localparam logic [1:0] C_SOLTA  = 2'd2;

  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    w_ks;
  logic [1:0]    state_q, state_d;
  logic          dono_q, dono_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          p0_q, p0_d, p1_q, p1_d, pr_q, pr_d, ocup_q;
  logic          w_own, w_other;

  // Keys are active-low; invert on entry so everything downstream is active-high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= ~KEY;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [DW-1:0] cnt_q;
    logic          ks_q;
    always_ff @(posedge Clk) begin
      if (Reset) begin
        cnt_q <= '0;
        ks_q  <= 1'b0;
      end else if (sync2_q[i] == ks_q) begin
        cnt_q <= '0;
      end else if (cnt_q == C_DB_LAST) begin
        ks_q  <= sync2_q[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign w_ks[i] = ks_q;
  end

  assign w_own   = dono_q ? w_ks[1] : w_ks[0];
  assign w_other = dono_q ? w_ks[0] : w_ks[1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= C_IDLE;
      dono_q  <= 1'b0;
      wcnt_q  <= '0;
      p0_q    <= 1'b0;
      p1_q    <= 1'b0;
      pr_q    <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dono_q  <= dono_d;
      wcnt_q  <= wcnt_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      pr_q    <= pr_d;
      ocup_q  <= (state_d != C_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    dono_d  = dono_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      C_IDLE: begin
        if (w_ks == 2'b11) begin
          state_d = C_SOLTA;
        end else if (w_ks != 2'b00) begin
          dono_d  = w_ks[1];
          wcnt_d  = '0;
          state_d = C_ESPERA;
        end
      end
      C_ESPERA: begin
        if (w_other)                    state_d = C_SOLTA;
        else if (!w_own)                state_d = C_IDLE;
        else if (wcnt_q == C_CH_LAST)   state_d = C_SOLTA;
        else                            wcnt_d  = wcnt_q + 1'b1;
      end
      C_SOLTA: begin
        if (w_ks == 2'b00) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Strobes are decoded from the transition being taken and registered next edge.
  always_comb begin
    p0_d = 1'b0;
    p1_d = 1'b0;
    pr_d = 1'b0;
    case (state_q)
      C_IDLE: pr_d = (w_ks == 2'b11);
      C_ESPERA: begin
        if (w_other) begin
          pr_d = 1'b1;
        end else if (!w_own || (wcnt_q == C_CH_LAST)) begin
          p0_d = ~dono_q;
          p1_d = dono_q;
        end
      end
      default: ;
    endcase
  end

  assign pulso_key0   = p0_q;
  assign pulso_key1   = p1_q;
  assign pedido_reset = pr_q;
  assign key0_estavel = w_ks[0];
  assign key1_estavel = w_ks[1];
  assign ocupado      = ocup_q;

endmodule
`default_nettype wire

// File: tb/tb_tratador_botoes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tratador_botoes: vector table plus directed corner sequences.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_tratador_botoes;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] KEY = 2'b11;
  logic       pulso_key0, pulso_key1, pedido_reset;
  logic       key0_estavel, key1_estavel, ocupado;

  tratador_botoes #(.DEBOUNCE_CYCLES(4), .CHORD_CYCLES(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .KEY          (KEY),
    .pulso_key0   (pulso_key0),
    .pulso_key1   (pulso_key1),
    .pedido_reset (pedido_reset),
    .key0_estavel (key0_estavel),
    .key1_estavel (key1_estavel),
    .ocupado      (ocupado)
  );

  always #5 Clk = ~Clk;

  // Observed bundle: {ocupado, key1_estavel, key0_estavel, pedido_reset, pulso_key1, pulso_key0}
  wire [5:0] obs = {ocupado, key1_estavel, key0_estavel, pedido_reset, pulso_key1, pulso_key0};

  typedef struct {
    logic       rst;
    logic [1:0] key;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic rst, input logic [1:0] key,
                              input logic [5:0] exp, input int n);
    vec_t v;
    v.rst = rst;
    v.key = key;
    v.exp = exp;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive inputs away from the active edge, then sample 1 time unit after it.
  task automatic step(input logic rst, input logic [1:0] key);
    @(negedge Clk);
    Reset = rst;
    KEY   = key;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int p0_n, p1_n, pr_n, p0_at, p1_at, pr_at;

    // Reset sanity, then idle
    add(1, 2'b11, 6'b000000, 3);
    add(0, 2'b11, 6'b000000, 3);
    // 3-cycle glitch on KEY0: never accepted
    add(0, 2'b10, 6'b000000, 3);
    add(0, 2'b11, 6'b000000, 8);
    // 4-cycle KEY0 press: just accepted, short tap strobe at E10
    add(0, 2'b10, 6'b000000, 4);
    add(0, 2'b11, 6'b000000, 1);
    add(0, 2'b11, 6'b001000, 1);
    add(0, 2'b11, 6'b101000, 3);
    add(0, 2'b11, 6'b100000, 1);
    add(0, 2'b11, 6'b000001, 1);
    add(0, 2'b11, 6'b000000, 4);
    // KEY0 held 40 cycles: stable at E5, busy at E6, strobe at E14 only
    add(0, 2'b10, 6'b000000, 5);
    add(0, 2'b10, 6'b001000, 1);
    add(0, 2'b10, 6'b101000, 8);
    add(0, 2'b10, 6'b101001, 1);
    add(0, 2'b10, 6'b101000, 25);
    // Release: stable drops at R+5, idle at R+6
    add(0, 2'b11, 6'b101000, 5);
    add(0, 2'b11, 6'b100000, 1);
    add(0, 2'b11, 6'b000000, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].key);
      check($sformatf("vec[%0d]", i), int'(obs), int'(tbl[i].exp));
    end

    // Short KEY1 tap of 8 cycles
    p0_n = 0; p1_n = 0; pr_n = 0; p1_at = -1;
    for (int e = 0; e < 30; e++) begin
      step(1'b0, (e < 8) ? 2'b01 : 2'b11);
      if (pulso_key1) begin p1_n++; p1_at = e; end
      if (pulso_key0) p0_n++;
      if (pedido_reset) pr_n++;
    end
    check("tap1_pulse_count", p1_n, 1);
    check("tap1_pulse_edge", p1_at, 14);
    check("tap1_other_strobes", p0_n + pr_n, 0);
    check("tap1_idle_after", int'(ocupado), 0);

    // Chord: KEY0 at E0, KEY1 at E3, both held to E32, released at E33
    p0_n = 0; p1_n = 0; pr_n = 0; pr_at = -1;
    for (int e = 0; e < 45; e++) begin
      step(1'b0, (e < 3) ? 2'b10 : (e < 33) ? 2'b00 : 2'b11);
      if (pedido_reset) begin pr_n++; pr_at = e; end
      if (pulso_key0) p0_n++;
      if (pulso_key1) p1_n++;
      if (e == 32) check("chord_busy_held", int'(ocupado), 1);
      if (e == 38) check("chord_busy_debounce", int'(ocupado), 1);
      if (e == 39) check("chord_idle_after", int'(ocupado), 0);
    end
    check("chord_req_count", pr_n, 1);
    check("chord_req_edge", pr_at, 9);
    check("chord_single_strobes", p0_n + p1_n, 0);

    // Reset in the middle of the window; KEY0 held throughout
    p0_n = 0; p0_at = -1; p1_n = 0; pr_n = 0;
    for (int e = 0; e < 52; e++) begin
      step(e == 10, (e < 41) ? 2'b10 : 2'b11);
      if (pulso_key0) begin p0_n++; p0_at = e; end
      if (pulso_key1) p1_n++;
      if (pedido_reset) pr_n++;
      if (e == 10) check("rst_mid_clears", int'(obs), 0);
      if (e == 14) check("rst_mid_no_e14_strobe", int'(pulso_key0), 0);
      if (e == 17) check("rst_mid_rearm_busy", int'(ocupado), 1);
    end
    check("rst_mid_pulse_count", p0_n, 1);
    check("rst_mid_pulse_edge", p0_at, 25);
    check("rst_mid_other_strobes", p1_n + pr_n, 0);
    check("rst_mid_idle_end", int'(ocupado), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tratador_botoes.md
# tratador_botoes

Conditions the two raw push-buttons before they reach the control unit. It synchronises KEY[1:0] into the slow-clock domain, debounces each key, and classifies each press as a single KEY0 action, a single KEY1 action, or a two-key chord. It emits one-cycle pulses that the control unit consumes directly as its KEY0/KEY1 strobes, plus a one-cycle manual-reset request for the global reset OR.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised level must differ from the stable level before it is accepted (≥2).
- CHORD_CYCLES, 8: window after a single-key press during which a second key turns it into a chord (≥2).

Ports:
- Clk  in  1  slow system clock (divided clock); all logic on rising edge.
- Reset  in  1  synchronous, active-high; clears every register on the next rising edge of Clk.
- KEY  in  2  raw buttons, active-low, asynchronous to Clk.
- pulso_key0  out  1  one-cycle strobe: KEY0 action.
- pulso_key1  out  1  one-cycle strobe: KEY1 action.
- pedido_reset  out  1  one-cycle strobe: both keys pressed (chord).
- key0_estavel  out  1  debounced KEY0 level, active-high = pressed.
- key1_estavel  out  1  debounced KEY1 level, active-high = pressed.
- ocupado  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: each key uses 2 flip-flops, inverted to active-high. The resulting value is k_sync[i].
- Debounce, per key, with stable level ks[i] and counter cnt[i] of width clog2(DEBOUNCE_CYCLES):
  - On an edge where k_sync==ks: cnt<=0.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1: ks<=k_sync and cnt<=0.
  - Otherwise: cnt++.
  - A glitch shorter than DEBOUNCE_CYCLES never changes ks.
- key*_estavel = ks (registered).
- FSM states: IDLE, ESPERA, SOLTA. The register `dono` records which key opened ESPERA. wcnt has width clog2(CHORD_CYCLES).
- IDLE:
  - ks==00: stay.
  - ks==11 (both in the same cycle): pedido_reset, go to SOLTA.
  - Exactly one ks high: dono<=that key, wcnt<=0, go to ESPERA.
- ESPERA, evaluated in this priority:
  1. Other key's ks=1: pedido_reset, go to SOLTA. No single pulse is emitted.
  2. ks[dono]=0 (short tap released): pulso_key[dono], go to IDLE.
  3. wcnt==CHORD_CYCLES-1: pulso_key[dono], go to SOLTA.
  4. Otherwise: wcnt++.
- SOLTA: go to IDLE when ks==00; otherwise stay. No outputs. A key that is held never auto-repeats.
- Output strobes are registered. Each is set on the transition edge and cleared on the next edge, so it is high for exactly one cycle. At most one strobe is high in any cycle.
- ocupado = (state != IDLE), registered with the state.

## Timing
- Reset value of every output and internal register is 0, and state = IDLE. Reset wins over all other activity.
- Reset mid-operation (any state, any counter value): no strobe is emitted on or after the reset edge.
- A key held through reset is seen as a fresh press after DEBOUNCE_CYCLES+2 edges, counted from the first edge after reset deasserts.
- Latency: let E0 be the first edge sampling KEY[i] low.
  - k_sync=1 after E1.
  - ks=1 after E(DEBOUNCE_CYCLES+1).
  - ESPERA is entered at E(DEBOUNCE_CYCLES+2).
  - A held single key strobes at E(DEBOUNCE_CYCLES+CHORD_CYCLES+2). With defaults that is E14, high until E15.
- Short tap: the strobe rises on the edge that evaluates ks[dono]=0, which is release + DEBOUNCE_CYCLES+2 edges.
- Chord: pedido_reset rises on the edge after the second key's ks rises, provided this happens within the window.
- A second key whose ks rises on the same edge as the window expiry loses. The single pulse fires and the FSM goes to SOLTA.
- A second key pressed while in SOLTA is ignored until both keys are released.

## Test plan
- Reset sanity: assert Reset for 3 cycles with KEY=11 → all outputs 0, ocupado=0. Release → outputs remain 0.
- Glitch rejection: with defaults, drive KEY[0]=0 for 3 cycles, then 1 → key0_estavel stays 0 and no strobe ever appears.
- Held KEY0: drive KEY[0]=0 from E0 and hold 40 cycles → key0_estavel=1 after E5, ocupado=1 after E6, pulso_key0 high exactly one cycle after E14, no further pulses. After release, ocupado returns to 0 at release + 6 edges.
- Short KEY1 tap: drive KEY[1] low for 8 cycles → exactly one pulso_key1, occurring before the window expires. pulso_key0 and pedido_reset stay 0.
- Chord: KEY[0] low at E0, KEY[1] low at E3, both held 30 cycles → exactly one pedido_reset pulse, no pulso_key0 or pulso_key1. ocupado stays 1 until both are released and debounced.
- Reset mid-window: KEY[0] low, Reset asserted at E10 (in ESPERA) for one cycle → no strobe at E14. The FSM restarts, and a fresh pulso_key0 fires DEBOUNCE_CYCLES+CHORD_CYCLES+2 edges after the first post-reset edge.
